// File: rtl/freq_est_win.sv
// Windowed rising zero-crossing counter with hysteresis; emits one count per WIN_LEN valid samples.
// Optional build macro FREQ_EST_BOTH_EDGES_EN also counts falling crossings (half-periods).
module freq_est_win #(
  parameter int W       = 16,
  parameter int CW      = 16,
  parameter int WIN_LEN = 1024,
  parameter int WIN_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] x,
  input  logic                v,
  input  logic signed [W-1:0] threshold,
  output logic [CW-1:0]       count,
  output logic                sat,
  output logic                vout
);

  typedef enum logic [1:0] {UNK, LOW, HIGH} state_t;

  state_t              state, state_nxt;
  logic signed [W-1:0] x_p0, thr_p0;
  logic                vld_p0;
  logic                lo_p1, hi_p1, vld_p1;
  logic [CW-1:0]       acc, acc_nxt;
  logic                sat_acc, sat_acc_nxt;
  logic [WIN_W-1:0]    win_cnt;
  logic                evt, win_end;
  logic signed [W:0]   x_ext, thr_c;

  // Negative thresholds collapse to zero so lo/hi can never both be true.
  function automatic logic signed [W:0] clamp_thr(input logic signed [W-1:0] t);
    return t[W-1] ? '0 : {1'b0, t};
  endfunction

  function automatic logic [CW:0] sat_inc(input logic [CW-1:0] a, input logic e);
    if (e && (a == {CW{1'b1}}))
      return {1'b1, a};
    return {1'b0, a + CW'(e)};
  endfunction

  // Stage 0: capture sample and threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      x_p0   <= '0;
      thr_p0 <= '0;
    end else begin
      vld_p0 <= v;
      if (v) begin
        x_p0   <= x;
        thr_p0 <= threshold;
      end
    end
  end

  assign x_ext = {x_p0[W-1], x_p0};
  assign thr_c = clamp_thr(thr_p0);

  // Stage 1: widened compares against the clamped threshold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      lo_p1  <= 1'b0;
      hi_p1  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      lo_p1  <= x_ext < -thr_c;
      hi_p1  <= x_ext > thr_c;
    end
  end

  // Stage 2: hysteresis FSM, accumulator, window counter, outputs
  always_comb begin
    state_nxt = state;
    evt       = 1'b0;
    if (vld_p1) begin
      case (state)
        UNK: begin
          if (lo_p1)      state_nxt = LOW;
          else if (hi_p1) state_nxt = HIGH;
        end
        LOW: begin
          if (hi_p1) begin
            state_nxt = HIGH;
            evt       = 1'b1;
          end
        end
        HIGH: begin
          if (lo_p1) begin
            state_nxt = LOW;
`ifdef FREQ_EST_BOTH_EDGES_EN
            evt       = 1'b1;
`else
            evt       = 1'b0;
`endif
          end
        end
        default: state_nxt = UNK;
      endcase
    end
  end

  assign {sat_acc_nxt, acc_nxt} = sat_inc(acc, evt) | {sat_acc, {CW{1'b0}}};
  assign win_end = vld_p1 && (win_cnt == WIN_W'(WIN_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= UNK;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      sat_acc <= 1'b0;
      win_cnt <= '0;
      count   <= '0;
      sat     <= 1'b0;
      vout    <= 1'b0;
    end else begin
      vout <= 1'b0;
      if (win_end) begin
        count   <= acc_nxt;
        sat     <= sat_acc_nxt;
        vout    <= 1'b1;
        acc     <= '0;
        sat_acc <= 1'b0;
        win_cnt <= '0;
      end else if (vld_p1) begin
        acc     <= acc_nxt;
        sat_acc <= sat_acc_nxt;
        win_cnt <= win_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_freq_est_win.sv
// Randomised and directed bench for freq_est_win; two instances (WIN_LEN=8/CW=16 and WIN_LEN=16/CW=2) share stimulus.
module tb_freq_est_win;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               v = 1'b0;
  logic signed [15:0] x = '0;
  logic signed [15:0] thr = '0;
  logic [15:0]        count_a;
  logic               sat_a, vout_a;
  logic [1:0]         count_b;
  logic               sat_b, vout_b;

  always #5 clk = ~clk;

  freq_est_win #(.W(16), .CW(16), .WIN_LEN(8), .WIN_W(16)) dut_a (
    .clk(clk), .rst(rst), .x(x), .v(v), .threshold(thr),
    .count(count_a), .sat(sat_a), .vout(vout_a));

  freq_est_win #(.W(16), .CW(2), .WIN_LEN(16), .WIN_W(16)) dut_b (
    .clk(clk), .rst(rst), .x(x), .v(v), .threshold(thr),
    .count(count_b), .sat(sat_b), .vout(vout_b));

`ifdef FREQ_EST_BOTH_EDGES_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  typedef struct {int xv; int tv; int due;} smp_t;
  smp_t pq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mst[2];
  int   macc[2];
  int   mn[2];
  int   cmax[2];
  int   wlen[2];
  logic ev_vout[2];
  int   ev_cnt[2];
  logic ev_sat[2];

  // Reference: sample takes effect two edges after capture; unbounded crossing tally clipped at window end.
  task automatic model_sample(input smp_t s);
    int tc;
    bit lo, hi;
    tc = (s.tv < 0) ? 0 : s.tv;
    lo = s.xv < -tc;
    hi = s.xv > tc;
    for (int d = 0; d < 2; d++) begin
      if (mst[d] == 0) begin
        if (lo) mst[d] = 1;
        else if (hi) mst[d] = 2;
      end else if (mst[d] == 1 && hi) begin
        mst[d] = 2;
        macc[d]++;
      end else if (mst[d] == 2 && lo) begin
        mst[d] = 1;
        if (BOTH) macc[d]++;
      end
      mn[d]++;
      if (mn[d] == wlen[d]) begin
        ev_vout[d] = 1'b1;
        ev_cnt[d]  = (macc[d] > cmax[d]) ? cmax[d] : macc[d];
        ev_sat[d]  = macc[d] > cmax[d];
        macc[d]    = 0;
        mn[d]      = 0;
      end
    end
  endtask

  task automatic tick(input logic vv, input int xx, input int tt, input logic rr);
    smp_t s;
    @(negedge clk);
    v = vv; x = 16'(xx); thr = 16'(tt); rst = rr;
    @(posedge clk);
    cyc++;
    ev_vout[0] = 1'b0;
    ev_vout[1] = 1'b0;
    if (rr) begin
      pq.delete();
      for (int d = 0; d < 2; d++) begin
        mst[d] = 0; macc[d] = 0; mn[d] = 0; ev_cnt[d] = 0; ev_sat[d] = 1'b0;
      end
    end else begin
      if (pq.size() > 0 && pq[0].due == cyc) begin
        s = pq.pop_front();
        model_sample(s);
      end
      if (vv) pq.push_back('{xx, tt, cyc + 2});
    end
    #1;
  endtask

  function automatic int sq(input int k);
    return ((k % 4) < 2) ? 1000 : -1000;
  endfunction

  task automatic test_reset();
    tick(1'b0, 0, 0, 1'b1);
    checks++;
    if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state got a=%b/%0d/%b b=%b/%0d/%b want all zero",
               vout_a, count_a, sat_a, vout_b, count_b, sat_b);
    end
  endtask

  task automatic test_square();
    int got[2];
    int at[2];
    int nv = 0;
    test_reset();
    for (int i = 0; i < 19; i++) begin
      tick(i < 16, sq(i), 100, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL square i=%0d got a=%b/%0d/%b b=%b/%0d/%b want a=%b/%0d/%b b=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, vout_b, count_b, sat_b,
                 ev_vout[0], ev_cnt[0], ev_sat[0], ev_vout[1], ev_cnt[1], ev_sat[1]);
      end
      if (vout_a === 1'b1 && nv < 2) begin
        got[nv] = count_a; at[nv] = i; nv++;
      end
    end
    checks++;
    if (nv != 2 || got[0] != (BOTH ? 3 : 1) || got[1] != (BOTH ? 4 : 2) || at[0] != 9 || at[1] != 17) begin
      errors++;
      $display("FAIL square_windows got n=%0d counts=%0d,%0d at=%0d,%0d want n=2 counts=%0d,%0d at=9,17",
               nv, got[0], got[1], at[0], at[1], BOTH ? 3 : 1, BOTH ? 4 : 2);
    end
  endtask

  task automatic test_hysteresis();
    test_reset();
    for (int i = 0; i < 35; i++) begin
      tick(i < 32, (i < 16) ? ((i % 2) ? -50 : 50) : ((i % 2) ? -100 : 100), 100, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]} ||
          (vout_a === 1'b1 && count_a !== 16'd0)) begin
        errors++;
        $display("FAIL hysteresis i=%0d got a=%b/%0d b=%b/%0d want a=%b/%0d b=%b/%0d", i,
                 vout_a, count_a, vout_b, count_b, ev_vout[0], ev_cnt[0], ev_vout[1], ev_cnt[1]);
      end
    end
  endtask

  task automatic test_bubbles();
    int got[2];
    int at[2];
    int nv = 0;
    bit vv;
    test_reset();
    for (int i = 0; i < 36; i++) begin
      vv = (i % 2 == 0) && (i < 32);
      tick(vv, vv ? sq(i / 2) : 32767, 100, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL bubbles i=%0d got a=%b/%0d/%b b=%b/%0d/%b want a=%b/%0d/%b b=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, vout_b, count_b, sat_b,
                 ev_vout[0], ev_cnt[0], ev_sat[0], ev_vout[1], ev_cnt[1], ev_sat[1]);
      end
      if (vout_a === 1'b1 && nv < 2) begin
        got[nv] = count_a; at[nv] = i; nv++;
      end
    end
    checks++;
    if (nv != 2 || got[0] != (BOTH ? 3 : 1) || got[1] != (BOTH ? 4 : 2) || at[0] != 16 || at[1] != 32) begin
      errors++;
      $display("FAIL bubbles_windows got n=%0d counts=%0d,%0d at=%0d,%0d want n=2 counts=%0d,%0d at=16,32",
               nv, got[0], got[1], at[0], at[1], BOTH ? 3 : 1, BOTH ? 4 : 2);
    end
  endtask

  task automatic test_saturation();
    int nb = 0;
    test_reset();
    for (int i = 0; i < 35; i++) begin
      tick(i < 32, (i < 16 && (i % 2)) ? -1000 : 1000, 100, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL saturation i=%0d got a=%b/%0d/%b b=%b/%0d/%b want a=%b/%0d/%b b=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, vout_b, count_b, sat_b,
                 ev_vout[0], ev_cnt[0], ev_sat[0], ev_vout[1], ev_cnt[1], ev_sat[1]);
      end
      if (vout_b === 1'b1) begin
        checks++;
        if ((nb == 0 && (count_b !== 2'd3 || sat_b !== 1'b1)) || (nb == 1 && sat_b !== 1'b0)) begin
          errors++;
          $display("FAIL saturation_window%0d got count=%0d sat=%b want %s", nb, count_b, sat_b,
                   (nb == 0) ? "count=3 sat=1" : "sat=0");
        end
        nb++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int at = -1;
    test_reset();
    for (int i = 0; i < 5; i++) tick(1'b1, sq(i), 100, 1'b0);
    tick(1'b0, 0, 100, 1'b1);
    checks++;
    if (vout_a !== 1'b0 || count_a !== 16'd0 || vout_b !== 1'b0 || count_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_state got vout=%b count=%0d want vout=0 count=0", vout_a, count_a);
    end
    for (int i = 0; i < 11; i++) begin
      tick(i < 8, sq(i), 100, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL reset_mid i=%0d got a=%b/%0d/%b b=%b/%0d/%b want a=%b/%0d/%b b=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, vout_b, count_b, sat_b,
                 ev_vout[0], ev_cnt[0], ev_sat[0], ev_vout[1], ev_cnt[1], ev_sat[1]);
      end
      if (vout_a === 1'b1 && at < 0) begin
        at = i;
        checks++;
        if (count_a !== (BOTH ? 16'd3 : 16'd1)) begin
          errors++;
          $display("FAIL reset_mid_count got %0d want %0d", count_a, BOTH ? 3 : 1);
        end
      end
    end
    checks++;
    if (at != 9) begin
      errors++;
      $display("FAIL reset_mid_timing got vout at %0d want 9", at);
    end
  endtask

  task automatic test_clamp();
    int seen = 0;
    test_reset();
    for (int i = 0; i < 11; i++) begin
      tick(i < 8, (i % 2) ? 1 : -1, -32768, 1'b0);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL clamp i=%0d got a=%b/%0d/%b want a=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, ev_vout[0], ev_cnt[0], ev_sat[0]);
      end
      if (vout_a === 1'b1) begin
        seen++;
        checks++;
        if (count_a !== (BOTH ? 16'd7 : 16'd4)) begin
          errors++;
          $display("FAIL clamp_count got %0d want %0d", count_a, BOTH ? 7 : 4);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL clamp_vout got %0d pulses want 1", seen);
    end
  endtask

  task automatic test_random();
    bit vv, rr;
    test_reset();
    for (int i = 0; i < 800; i++) begin
      vv = $urandom_range(0, 9) < 7;
      rr = $urandom_range(0, 199) == 0;
      tick(vv && !rr, int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 300)) - 50, rr);
      checks++;
      if ({vout_a, count_a, sat_a, vout_b, count_b, sat_b} !==
          {ev_vout[0], 16'(ev_cnt[0]), ev_sat[0], ev_vout[1], 2'(ev_cnt[1]), ev_sat[1]}) begin
        errors++;
        $display("FAIL random i=%0d got a=%b/%0d/%b b=%b/%0d/%b want a=%b/%0d/%b b=%b/%0d/%b", i,
                 vout_a, count_a, sat_a, vout_b, count_b, sat_b,
                 ev_vout[0], ev_cnt[0], ev_sat[0], ev_vout[1], ev_cnt[1], ev_sat[1]);
      end
    end
  endtask

  initial begin
    cmax[0] = 65535; cmax[1] = 3;
    wlen[0] = 8;     wlen[1] = 16;
    test_reset();
    test_square();
    test_hysteresis();
    test_bubbles();
    test_saturation();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_est_win.md
Name: freq_est_win

Overview:
- Windowed, hysteresis-based rising zero-crossing counter for the linear-prediction front end.
- Successor to the fixed 16-bit three-tap crossing counter. Adds:
  - parametrised sample and count widths
  - a persistent hysteresis state machine, so crossings separated by gaps or slow slopes are still counted
  - a fixed-length measurement window that emits one count per WIN_LEN valid samples
  - a saturation flag
- Sits between the sample source and the pitch/frequency estimator; the downstream consumer reads count on each vout pulse.

Parameters:
- W, 16, sample and threshold width (signed)
- CW, 16, crossing count width (unsigned)
- WIN_LEN, 1024, valid samples per measurement window; range 2..65535
- WIN_W, 16, width of the internal window sample counter; must satisfy WIN_LEN <= 2^WIN_W - 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- x  in  W  signed input sample
- v  in  1  sample valid; x is ignored when v=0
- threshold  in  W  signed hysteresis threshold; sampled together with x when v=1
- count  out  CW  crossings in the last completed window
- sat  out  1  last completed window's count saturated
- vout  out  1  one-cycle pulse: count/sat updated

Behaviour:
- Reset: one clock; the port polarity and synchronous behaviour are fixed as above.
  - Clears every pipeline register, including the valid stages.
  - count=0, sat=0, vout=0; FSM=UNK; accumulator=0; window counter=0.
  - Reset mid-window discards the partial window. No vout is produced for it.
- Pipeline, 3 stages:
  - Stage 0 (edge E, v=1): capture x and threshold.
  - Stage 1 (edge E+1): register the compares.
    - thr_c = max(threshold, 0).
    - lo = x < -thr_c and hi = x > thr_c, both strict.
    - Compares are evaluated at W+1 bits so that negating 0x7FFF..., or a clamped negative, never overflows.
  - Stage 2 (edge E+2): FSM update, accumulator, window counter, outputs.
  - The final sample of a window presented at edge E gives vout=1 and the new count in the cycle after edge E+2.
- Bubbles: v=0 cycles advance nothing; each valid sample is processed exactly once. Back-to-back valid samples are accepted every cycle; there is no backpressure.
- FSM (advances only on stage-2 valid):
  - UNK: lo -> LOW; hi -> HIGH, no count; else stay.
  - LOW: hi -> HIGH and crossing event; else stay.
  - HIGH: lo -> LOW; else stay.
  - lo and hi are mutually exclusive, since thr_c >= 0.
  - FSM state persists across window boundaries.
- Accumulator:
  - acc_next = acc + event, saturating at 2^CW-1.
  - sat_acc is set on an attempted increment beyond the maximum.
- Window counter:
  - Increments per stage-2 valid.
  - When it equals WIN_LEN-1 on a valid, this is the window end:
    - count <= acc_next and sat <= sat_acc_next, so the final sample's event is included.
    - vout <= 1.
    - acc, sat_acc and the window counter are cleared to 0.
- Otherwise vout <= 0, and count/sat hold their value.

Optional Feature:
- Macro: FREQ_EST_BOTH_EDGES_EN
  - Defined: the HIGH->LOW transition on lo also generates a crossing event. count reports half-periods.
  - Undefined: only LOW->HIGH events are counted.
- All other behaviour is identical in both builds.

Test Plan:
- Square wave, WIN_LEN=8, thr=100, x=+1000,+1000,-1000,-1000 repeating, v=1 continuous from reset:
  - Expected: first vout count=1, second count=2, sat=0.
  - With FREQ_EST_BOTH_EDGES_EN: 3 then 4.
  - vout must occur exactly 2 edges after the 8th and 16th valid sample edges.
- Hysteresis, thr=100, x alternating +50/-50, and separately x = +100/-100 exactly, 16 samples:
  - Expected: count=0 on both vout pulses.
- Bubbles: repeat the square-wave case with v=1 every other cycle and x=0x7FFF garbage on v=0 cycles.
  - Expected: same counts as the continuous case; vout is delayed accordingly.
- Saturation, CW=2, WIN_LEN=16, x=+1000/-1000 alternating from reset:
  - Expected: 7 rising events; count=3, sat=1.
  - Next window with x constant +1000: count=0, sat=0.
- Reset mid-window, WIN_LEN=8: assert rst for 1 cycle after 5 samples of the square wave.
  - Expected: vout=0 and count=0 after reset.
  - Next vout only after 8 fresh samples.
  - The first HIGH after reset is not counted.
- Threshold clamp: thr=0x8000 (most negative), x=-1,+1 repeating, WIN_LEN=8.
  - Expected: behaves as thr=0, count=4.
